// File: rtl/div_pkg.sv
// Shared types and constants for the iterative divider.
// Exposes the FSM state type, datapath widths and the divide-by-zero quotient.
package div_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_RUN,
        DIV_DONE
    } div_state_t;

    localparam int DIV_W     = 32;
    localparam int DIV_CNT_W = $clog2(32) + 1;

    localparam logic [DIV_W-1:0] DIV_ZERO_QUO = 32'hFFFF_FFFF;

    // Magnitude of v when treated as signed, raw value otherwise.
    function automatic logic [DIV_W-1:0] div_mag(
        input logic [DIV_W-1:0] v,
        input logic             sgn
    );
        return (sgn && v[DIV_W-1]) ? (DIV_W'(0) - v) : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step on a {rem, quo} shift register, MSB first.
// Ports: rem_in/quo_in/divisor in, rem_out/quo_out out (all DIV_W bits).
module div_step
    import div_pkg::*;
(
    input  logic [DIV_W-1:0] rem_in,
    input  logic [DIV_W-1:0] quo_in,
    input  logic [DIV_W-1:0] divisor,
    output logic [DIV_W-1:0] rem_out,
    output logic [DIV_W-1:0] quo_out
);

    logic [DIV_W:0] shifted;
    logic [DIV_W:0] diff;
    logic           fits;

    // Partial remainder can reach 33 bits before the trial subtract.
    assign shifted = {rem_in, quo_in[DIV_W-1]};
    assign diff    = shifted - {1'b0, divisor};
    assign fits    = ~diff[DIV_W];

    // On success the difference is below divisor, on failure the
    // shifted value is below divisor, so both fit in DIV_W bits.
    assign rem_out = fits ? diff[DIV_W-1:0] : shifted[DIV_W-1:0];
    assign quo_out = {quo_in[DIV_W-2:0], fits};

endmodule

// File: rtl/div_unit.sv
// Iterative signed/unsigned divider returning {quotient, remainder}.
// Ports: clk, rst (async active-low), div_sel/div_sign/div_op_a/div_op_b
//   request, flush, pipe_stall; div_result, div_valid, div_busy.
// Option: define DIV_FAST_PATH_EN to finish zero-divisor and |a|<|b|
//   requests straight from IDLE.
module div_unit
    import div_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                div_sel,
    input  logic                div_sign,
    input  logic [DATA_W-1:0]   div_op_a,
    input  logic [DATA_W-1:0]   div_op_b,
    input  logic                flush,
    input  logic                pipe_stall,
    output logic [2*DATA_W-1:0] div_result,
    output logic                div_valid,
    output logic                div_busy
);

    localparam int N_ITER = DIV_W / BITS_PER_CYCLE;
    localparam logic [DIV_CNT_W-1:0] LAST_CNT = DIV_CNT_W'(N_ITER - 1);

    div_state_t state;
    div_state_t state_nxt;

    logic [DIV_CNT_W-1:0] cnt;
    logic [DIV_W-1:0]     rem_q;
    logic [DIV_W-1:0]     quo_q;
    logic [DIV_W-1:0]     dvsr_q;
    logic [DIV_W-1:0]     dvnd_q;
    logic                 q_neg_q;
    logic                 r_neg_q;
    logic                 b_zero_q;
    logic [2*DIV_W-1:0]   result_q;

    logic [DIV_W-1:0]     mag_a;
    logic [DIV_W-1:0]     mag_b;
    logic                 b_zero;
    logic                 fast;
    logic [2*DIV_W-1:0]   fast_res;
    logic                 last;

    logic [DIV_W-1:0]     q_fix;
    logic [DIV_W-1:0]     r_fix;
    logic [2*DIV_W-1:0]   final_res;

    logic [DIV_W-1:0]     rem_c [BITS_PER_CYCLE+1];
    logic [DIV_W-1:0]     quo_c [BITS_PER_CYCLE+1];

    assign mag_a  = div_mag(div_op_a, div_sign);
    assign mag_b  = div_mag(div_op_b, div_sign);
    assign b_zero = (div_op_b == '0);
    assign last   = (cnt == LAST_CNT);

`ifdef DIV_FAST_PATH_EN
    assign fast = b_zero || (mag_a < mag_b);
`else
    assign fast = 1'b0;
`endif

    // Short-cut results use the dividend as given: no sign fixup.
    assign fast_res = b_zero ? {DIV_ZERO_QUO, div_op_a}
                             : {{DIV_W{1'b0}}, div_op_a};

    assign rem_c[0] = rem_q;
    assign quo_c[0] = quo_q;

    for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_step
        div_step u_step (
            .rem_in  (rem_c[g]),
            .quo_in  (quo_c[g]),
            .divisor (dvsr_q),
            .rem_out (rem_c[g+1]),
            .quo_out (quo_c[g+1])
        );
    end

    assign q_fix = q_neg_q ? (DIV_W'(0) - quo_c[BITS_PER_CYCLE])
                           : quo_c[BITS_PER_CYCLE];
    assign r_fix = r_neg_q ? (DIV_W'(0) - rem_c[BITS_PER_CYCLE])
                           : rem_c[BITS_PER_CYCLE];

    assign final_res = b_zero_q ? {DIV_ZERO_QUO, dvnd_q}
                                : {q_fix, r_fix};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= DIV_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = DIV_IDLE;
        end else begin
            unique case (state)
                DIV_IDLE: begin
                    if (div_sel) begin
                        state_nxt = fast ? DIV_DONE : DIV_RUN;
                    end
                end
                DIV_RUN: begin
                    if (last) begin
                        state_nxt = DIV_DONE;
                    end
                end
                DIV_DONE: begin
                    if (!pipe_stall) begin
                        state_nxt = DIV_IDLE;
                    end
                end
                default: state_nxt = DIV_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvsr_q   <= '0;
            dvnd_q   <= '0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            b_zero_q <= 1'b0;
            result_q <= '0;
        end else if (!flush) begin
            unique case (state)
                DIV_IDLE: begin
                    if (div_sel) begin
                        cnt      <= '0;
                        rem_q    <= '0;
                        quo_q    <= mag_a;
                        dvsr_q   <= mag_b;
                        dvnd_q   <= div_op_a;
                        q_neg_q  <= div_sign & (div_op_a[DIV_W-1]
                                              ^ div_op_b[DIV_W-1]);
                        r_neg_q  <= div_sign & div_op_a[DIV_W-1];
                        b_zero_q <= b_zero;
                        if (fast) begin
                            result_q <= fast_res;
                        end
                    end
                end
                DIV_RUN: begin
                    rem_q <= rem_c[BITS_PER_CYCLE];
                    quo_q <= quo_c[BITS_PER_CYCLE];
                    cnt   <= cnt + 1'b1;
                    if (last) begin
                        result_q <= final_res;
                    end
                end
                default: ;
            endcase
        end
    end

    assign div_result = result_q;
    assign div_valid  = (state == DIV_DONE);
    assign div_busy   = (state == DIV_RUN);

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit.
// Expected values are hand-computed per vector.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        div_sel = 1'b0;
    logic        div_sign = 1'b0;
    logic [31:0] div_op_a = '0;
    logic [31:0] div_op_b = '0;
    logic        flush = 1'b0;
    logic        pipe_stall = 1'b0;
    logic [63:0] div_result;
    logic        div_valid;
    logic        div_busy;

    int n_chk  = 0;
    int n_pass = 0;

`ifdef DIV_FAST_PATH_EN
    localparam int FAST_LAT = 1;
`else
    localparam int FAST_LAT = 33;
`endif

    always #5 clk = ~clk;

    div_unit u_dut (
        .clk        (clk),
        .rst        (rst),
        .div_sel    (div_sel),
        .div_sign   (div_sign),
        .div_op_a   (div_op_a),
        .div_op_b   (div_op_b),
        .flush      (flush),
        .pipe_stall (pipe_stall),
        .div_result (div_result),
        .div_valid  (div_valid),
        .div_busy   (div_busy)
    );

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Request sampled at the next rising edge (cycle T); div_sel is
    // dropped right after, so the op must still complete.
    task automatic start_div(input logic sgn,
                             input logic [31:0] a,
                             input logic [31:0] b);
        @(negedge clk);
        div_sel  = 1'b1;
        div_sign = sgn;
        div_op_a = a;
        div_op_b = b;
        @(posedge clk);
        #1;
        div_sel = 1'b0;
    endtask

    // Returns n where div_valid first seen in cycle T+n.
    task automatic wait_valid(output int n);
        n = 1;
        while (!div_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic do_div(input string tag,
                          input logic sgn,
                          input logic [31:0] a,
                          input logic [31:0] b,
                          input logic [63:0] exp,
                          input int lat);
        int n;
        start_div(sgn, a, b);
        wait_valid(n);
        chk({tag, "_lat"}, 64'(n), 64'(lat));
        chk({tag, "_res"}, div_result, exp);
        @(posedge clk);
        #1;
        chk({tag, "_1cyc"}, {62'd0, div_valid, div_busy}, 64'd0);
    endtask

    initial begin
        int n;
        int vcnt;
        int vhi;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 64'(div_valid), 64'd0);
        chk("rst_busy", 64'(div_busy), 64'd0);
        chk("rst_result", div_result, 64'd0);
        @(negedge clk);
        rst = 1'b1;

        // Test 1, plus busy during DIV
        start_div(1'b0, 32'd100, 32'd7);
        chk("t1_busy", 64'(div_busy), 64'd1);
        wait_valid(n);
        chk("t1_lat", 64'(n), 64'd33);
        chk("t1_res", div_result, 64'h0000000E_00000002);
        @(posedge clk);
        #1;

        // Test 2
        do_div("t2a", 1'b1, 32'hFFFFFFF9, 32'd2,
               64'hFFFFFFFD_FFFFFFFF, 33);
        do_div("t2b", 1'b1, 32'd7, 32'hFFFFFFFE,
               64'hFFFFFFFD_00000001, 33);

        // Test 3 and zero-divisor corners
        do_div("t3a", 1'b1, 32'h80000000, 32'hFFFFFFFF,
               64'h80000000_00000000, 33);
        do_div("t3b", 1'b0, 32'd5, 32'd0,
               64'hFFFFFFFF_00000005, FAST_LAT);
        do_div("t3c", 1'b1, 32'hFFFFFFFB, 32'd0,
               64'hFFFFFFFF_FFFFFFFB, FAST_LAT);
        do_div("t3d", 1'b0, 32'hFFFFFFFF, 32'd1,
               64'hFFFFFFFF_00000000, 33);

        // Test 4: flush at T+10
        start_div(1'b0, 32'hFFFFFFFF, 32'd3);
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("t4_idle", {62'd0, div_valid, div_busy}, 64'd0);
        vhi = 0;
        for (int i = 0; i < 30; i++) begin
            if (div_valid) vhi++;
            @(posedge clk);
            #1;
        end
        chk("t4_novalid", 64'(vhi), 64'd0);
        do_div("t4_new", 1'b0, 32'd9, 32'd3,
               64'h00000003_00000000, 33);

        // flush together with div_sel in IDLE
        @(negedge clk);
        div_sel  = 1'b1;
        div_sign = 1'b0;
        div_op_a = 32'd50;
        div_op_b = 32'd5;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        div_sel = 1'b0;
        flush   = 1'b0;
        chk("fl_sel", {62'd0, div_valid, div_busy}, 64'd0);

        // Test 5: hold DONE for 3 extra cycles
        start_div(1'b0, 32'd100, 32'd7);
        pipe_stall = 1'b1;
        wait_valid(n);
        vcnt = 0;
        vhi  = 0;
        while (div_valid && vcnt < 10) begin
            vcnt++;
            if (div_result !== 64'h0000000E_00000002) vhi++;
            if (vcnt == 4) pipe_stall = 1'b0;
            @(posedge clk);
            #1;
        end
        pipe_stall = 1'b0;
        chk("t5_vcnt", 64'(vcnt), 64'd4);
        chk("t5_stable", 64'(vhi), 64'd0);
        do_div("t5_b2b", 1'b0, 32'd8, 32'd2,
               64'h00000004_00000000, 33);

        // Test 6: small dividend
        do_div("t6a", 1'b0, 32'd3, 32'd10,
               64'h00000000_00000003, FAST_LAT);
        do_div("t6b", 1'b1, 32'hFFFFFFFD, 32'd10,
               64'h00000000_FFFFFFFD, FAST_LAT);

        // Reset mid-operation
        start_div(1'b0, 32'd100, 32'd7);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_mid", {div_result, 62'd0, div_valid, div_busy} != 0
            ? 64'd1 : 64'd0, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        do_div("post_rst", 1'b0, 32'd21, 32'd4,
               64'h00000005_00000001, 33);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
